stopwatch_core: RTL and testbench

STOPWATCH_CORE -- requirements
Module: stopwatch_core

---
 rtl/stopwatch_core.sv | 147 ++++++++++++++
 tb/tb_stopwatch_core.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch core: edge-detected timebase/button inputs, RUN/PAUSE FSM,
// 2 Hz field adjust. Define STOPWATCH_BLINK_EN for blinking of the adjusted field.
module stopwatch_core #(
  parameter int ADJ_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       one_hz,
  input  logic       thirty_two_hz,
  input  logic       btn_pause,
  input  logic       btn_clr,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       blank_min,
  output logic       blank_sec
);

  localparam int PW = $clog2(ADJ_DIV + 1);

  typedef enum logic {PAUSE = 1'b0, RUN = 1'b1} state_t;

  state_t          state_q, state_n;
  logic [7:0]      sec_q, sec_n, min_q, min_n;
  logic [PW-1:0]   presc_q, presc_n;
  logic            one_hz_q, fast_q, pause_q, clr_q;
  logic            sec_tick, fast_tick, pause_tick, clr_tick;

  // BCD 00..59 increment, wrapping 59 -> 00
  function automatic logic [7:0] inc60(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) r = 8'h00;
      else                r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  assign sec_tick   = one_hz        & ~one_hz_q;
  assign fast_tick  = thirty_two_hz & ~fast_q;
  assign pause_tick = btn_pause     & ~pause_q;
  assign clr_tick   = btn_clr       & ~clr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      one_hz_q <= 1'b0;
      fast_q   <= 1'b0;
      pause_q  <= 1'b0;
      clr_q    <= 1'b0;
      state_q  <= PAUSE;
      sec_q    <= 8'h00;
      min_q    <= 8'h00;
      presc_q  <= '0;
    end else begin
      one_hz_q <= one_hz;
      fast_q   <= thirty_two_hz;
      pause_q  <= btn_pause;
      clr_q    <= btn_clr;
      state_q  <= state_n;
      sec_q    <= sec_n;
      min_q    <= min_n;
      presc_q  <= presc_n;
    end
  end

  // Clear outranks everything; the seconds tick uses the pre-toggle state.
  always_comb begin
    state_n = state_q;
    sec_n   = sec_q;
    min_n   = min_q;
    presc_n = presc_q;
    if (pause_tick) state_n = (state_q == RUN) ? PAUSE : RUN;
    if (clr_tick) begin
      sec_n   = 8'h00;
      min_n   = 8'h00;
      presc_n = '0;
    end else if (adj) begin
      if (fast_tick) begin
        if (presc_q == PW'(ADJ_DIV - 1)) begin
          presc_n = '0;
          if (sel) sec_n = inc60(sec_q);
          else     min_n = inc60(min_q);
        end else begin
          presc_n = presc_q + PW'(1);
        end
      end
    end else begin
      presc_n = '0;
      if (sec_tick && state_q == RUN) begin
        sec_n = inc60(sec_q);
        if (sec_q == 8'h59) min_n = inc60(min_q);
      end
    end
  end

  assign min_tens = min_q[7:4];
  assign min_ones = min_q[3:0];
  assign sec_tens = sec_q[7:4];
  assign sec_ones = sec_q[3:0];
  assign running  = (state_q == RUN);

`ifdef STOPWATCH_BLINK_EN
  logic [2:0] blink_cnt_q, blink_cnt_n;
  logic       phase_q, phase_n;
  logic       blank_min_q, blank_sec_q;

  always_comb begin
    blink_cnt_n = blink_cnt_q;
    phase_n     = phase_q;
    if (!adj) begin
      blink_cnt_n = 3'd0;
      phase_n     = 1'b0;
    end else if (fast_tick) begin
      blink_cnt_n = blink_cnt_q + 3'd1;
      if (blink_cnt_q == 3'd7) phase_n = ~phase_q;
    end
  end

  // Blank flags are registered from the next phase so they track the phase flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= 3'd0;
      phase_q     <= 1'b0;
      blank_min_q <= 1'b0;
      blank_sec_q <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_n;
      phase_q     <= phase_n;
      blank_min_q <= adj & ~sel & phase_n;
      blank_sec_q <= adj &  sel & phase_n;
    end
  end

  assign blank_min = blank_min_q;
  assign blank_sec = blank_sec_q;
`else
  assign blank_min = 1'b0;
  assign blank_sec = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: integer minutes/seconds model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_stopwatch_core;

  localparam int ADJ_DIV = 16;
`ifdef STOPWATCH_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       one_hz = 1'b0, thirty_two_hz = 1'b0, btn_pause = 1'b0, btn_clr = 1'b0;
  logic       adj = 1'b0, sel = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, blank_min, blank_sec;

  int checks = 0;
  int errors = 0;

  stopwatch_core #(.ADJ_DIV(ADJ_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .one_hz(one_hz), .thirty_two_hz(thirty_two_hz),
    .btn_pause(btn_pause), .btn_clr(btn_clr), .adj(adj), .sel(sel),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .blank_min(blank_min), .blank_sec(blank_sec)
  );

  always #5 clk = ~clk;

  // Model: plain integers, updated by the stated rules on each rising clk.
  int m_min, m_sec, m_pre, m_blk;
  bit m_run, m_bmin, m_bsec;
  bit p1, p32, pp, pc;

  always @(posedge clk or negedge rst_n) begin
    bit t1, t32, tp, tc, was_run, ph;
    if (!rst_n) begin
      m_min = 0; m_sec = 0; m_pre = 0; m_blk = 0;
      m_run = 0; m_bmin = 0; m_bsec = 0;
      p1 = 0; p32 = 0; pp = 0; pc = 0;
    end else begin
      t1 = one_hz & !p1; t32 = thirty_two_hz & !p32;
      tp = btn_pause & !pp; tc = btn_clr & !pc;
      was_run = m_run;
      if (tp) m_run = !m_run;
      if (tc) begin
        m_min = 0; m_sec = 0; m_pre = 0;
      end else if (adj) begin
        if (t32) begin
          m_pre++;
          if (m_pre == ADJ_DIV) begin
            m_pre = 0;
            if (sel) m_sec = (m_sec + 1) % 60;
            else     m_min = (m_min + 1) % 60;
          end
        end
      end else begin
        m_pre = 0;
        if (t1 && was_run) begin
          m_sec++;
          if (m_sec == 60) begin m_sec = 0; m_min = (m_min + 1) % 60; end
        end
      end
      if (!adj) m_blk = 0;
      else if (t32) m_blk++;
      ph = BLINK_ON && adj && ((m_blk / 8) % 2 == 1);
      m_bmin = ph && !sel;
      m_bsec = ph && sel;
      p1 = one_hz; p32 = thirty_two_hz; pp = btn_pause; pc = btn_clr;
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_min", min_tens * 10 + min_ones, m_min);
    chk("model_sec", sec_tens * 10 + sec_ones, m_sec);
    chk("model_run", running, m_run);
    chk("model_bmin", blank_min, m_bmin);
    chk("model_bsec", blank_sec, m_bsec);
    chk("model_bcd", (min_tens <= 5 && min_ones <= 9 && sec_tens <= 5 && sec_ones <= 9), 1);
  end

  task automatic chk_time(input string nm, input int mm, input int ss, input int run);
    chk({nm, "_mt"}, min_tens, mm / 10);
    chk({nm, "_mo"}, min_ones, mm % 10);
    chk({nm, "_st"}, sec_tens, ss / 10);
    chk({nm, "_so"}, sec_ones, ss % 10);
    chk({nm, "_run"}, running, run);
  endtask

  task automatic pulse_sec();
    @(negedge clk) one_hz = 1'b1;
    @(negedge clk) one_hz = 1'b0;
  endtask

  task automatic pulse_fast();
    @(negedge clk) thirty_two_hz = 1'b1;
    @(negedge clk) thirty_two_hz = 1'b0;
  endtask

  task automatic pulse_pause();
    @(negedge clk) btn_pause = 1'b1;
    @(negedge clk) btn_pause = 1'b0;
  endtask

  task automatic adjust(input bit s, input int n);
    @(negedge clk) begin adj = 1'b1; sel = s; end
    repeat (n * ADJ_DIV) pulse_fast();
    @(negedge clk) adj = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_time("reset", 0, 0, 0);
    chk("reset_bmin", blank_min, 0);
    chk("reset_bsec", blank_sec, 0);
    rst_n = 1'b1;

    // start, three seconds
    pulse_pause();
    repeat (3) pulse_sec();
    @(negedge clk) chk_time("run3", 0, 3, 1);
    pulse_pause();
    pulse_sec();
    @(negedge clk) chk_time("paused_hold", 0, 3, 0);

    // preload 09:59 and roll to 10:00
    @(negedge clk) btn_clr = 1'b1;
    @(negedge clk) btn_clr = 1'b0;
    adjust(1'b0, 9);
    adjust(1'b1, 59);
    @(negedge clk) chk_time("preload", 9, 59, 0);
    pulse_pause();
    pulse_sec();
    @(negedge clk) chk_time("roll_min", 10, 0, 1);

    // seconds adjust at 2 Hz, no carry on wrap
    @(negedge clk) begin adj = 1'b1; sel = 1'b1; end
    repeat (32) pulse_fast();
    chk_time("adj32", 10, 2, 1);
    repeat (57 * ADJ_DIV) pulse_fast();
    chk_time("adj59", 10, 59, 1);
    repeat (ADJ_DIV) pulse_fast();
    chk_time("adj_wrap", 10, 0, 1);
    @(negedge clk) adj = 1'b0;

    // 59:59 -> 00:00
    adjust(1'b0, 49);
    adjust(1'b1, 59);
    @(negedge clk) chk_time("at5959", 59, 59, 1);
    pulse_sec();
    @(negedge clk) chk_time("wrap_all", 0, 0, 1);

    // clear beats a coincident seconds tick
    adjust(1'b0, 12);
    adjust(1'b1, 34);
    @(negedge clk) begin btn_clr = 1'b1; one_hz = 1'b1; end
    @(negedge clk) begin chk_time("clr_prio", 0, 0, 1); btn_clr = 1'b0; one_hz = 1'b0; end

    // pause toggle with coincident tick uses pre-toggle state
    @(negedge clk) begin btn_pause = 1'b1; one_hz = 1'b1; end
    @(negedge clk) begin chk_time("toggle_run", 0, 1, 0); btn_pause = 1'b0; one_hz = 1'b0; end
    @(negedge clk) begin btn_pause = 1'b1; one_hz = 1'b1; end
    @(negedge clk) begin chk_time("toggle_pause", 0, 1, 1); btn_pause = 1'b0; one_hz = 1'b0; end

    // asynchronous reset between edges
    adjust(1'b0, 5);
    adjust(1'b1, 16);
    @(negedge clk) chk_time("pre_rst", 5, 17, 1);
    #2 rst_n = 1'b0;
    #1 chk_time("async_rst", 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;

    // blink of minutes field
    @(negedge clk) begin adj = 1'b1; sel = 1'b0; end
    repeat (7) pulse_fast();
    chk("blink7_min", blank_min, 0);
    pulse_fast();
    chk("blink8_min", blank_min, BLINK_ON);
    chk("blink8_sec", blank_sec, 0);
    repeat (8) pulse_fast();
    chk("blink16_min", blank_min, 0);
    repeat (8) pulse_fast();
    chk("blink24_min", blank_min, BLINK_ON);
    @(negedge clk) adj = 1'b0;
    @(negedge clk) chk("blink_off", blank_min, 0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
